// File: rtl/dispatch_queue_pkg.sv
// rtl/dispatch_queue_pkg.sv - opcode codes, tag constants and helpers shared by dispatch_queue
package dispatch_queue_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Tag value meaning "operand does not wait on any ROB entry"
    localparam int unsigned ZERO_ROB = 0;

    // Decoded opcode numbering; loads and stores occupy one contiguous range
    localparam int unsigned OPENUM_NOP   = 0;
    localparam int unsigned OPENUM_LUI   = 1;
    localparam int unsigned OPENUM_AUIPC = 2;
    localparam int unsigned OPENUM_JAL   = 3;
    localparam int unsigned OPENUM_JALR  = 4;
    localparam int unsigned OPENUM_BEQ   = 5;
    localparam int unsigned OPENUM_BNE   = 6;
    localparam int unsigned OPENUM_BLT   = 7;
    localparam int unsigned OPENUM_BGE   = 8;
    localparam int unsigned OPENUM_BLTU  = 9;
    localparam int unsigned OPENUM_BGEU  = 10;
    localparam int unsigned OPENUM_LB    = 11;
    localparam int unsigned OPENUM_LH    = 12;
    localparam int unsigned OPENUM_LW    = 13;
    localparam int unsigned OPENUM_LBU   = 14;
    localparam int unsigned OPENUM_LHU   = 15;
    localparam int unsigned OPENUM_SB    = 16;
    localparam int unsigned OPENUM_SH    = 17;
    localparam int unsigned OPENUM_SW    = 18;
    localparam int unsigned OPENUM_ADDI  = 19;
    localparam int unsigned OPENUM_ADD   = 28;
    localparam int unsigned OPENUM_AND   = 37;

    // Memory ops go to the load/store buffer, everything else to the reservation station
    function automatic logic is_mem_op(input int unsigned op);
        return (op >= OPENUM_LB) && (op <= OPENUM_SW);
    endfunction

endpackage

// File: rtl/dispatch_queue_operand_resolver.sv
// rtl/dispatch_queue_operand_resolver.sv - combinational operand forwarding from CDB, ROB or register file
module operand_resolver
    import dispatch_queue_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int NUM_CDB  = 2
)(
    input  logic [ROB_ID_W-1:0]         i_q_from_reg,
    input  logic [DATA_W-1:0]           i_v_from_reg,
    input  logic                        i_rob_ready,
    input  logic [DATA_W-1:0]           i_rob_data,
    input  logic [NUM_CDB-1:0]          i_cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] i_cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]   i_cdb_result,
    output logic [ROB_ID_W-1:0]         o_q,
    output logic [DATA_W-1:0]           o_v
);

    logic              w_pending;
    logic              w_cdb_hit;
    logic [DATA_W-1:0] w_cdb_data;

    assign w_pending = (i_q_from_reg != ROB_ID_W'(ZERO_ROB));

    // Scan channels high to low so the lowest matching channel writes last and wins
    always_comb begin
        w_cdb_hit  = FALSE;
        w_cdb_data = '0;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (i_cdb_valid[i] && (i_cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] == i_q_from_reg)) begin
                w_cdb_hit  = TRUE;
                w_cdb_data = i_cdb_result[i*DATA_W +: DATA_W];
            end
        end
    end

    // A pending tag is satisfied by a CDB broadcast first, then by an already-finished ROB entry
    always_comb begin
        o_q = i_q_from_reg;
        o_v = i_v_from_reg;
        if (w_pending && w_cdb_hit) begin
            o_q = '0;
            o_v = w_cdb_data;
        end else if (w_pending && i_rob_ready) begin
            o_q = '0;
            o_v = i_rob_data;
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - FIFO-buffered dispatcher to RS/LSB with operand forwarding; optional DISPATCH_STATS_EN counters
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int REG_W    = 5,
    parameter int OP_W     = 6,
    parameter int DEPTH    = 4,
    parameter int NUM_CDB  = 2
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rdy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_W-1:0]           in_pc,
    input  logic [OP_W-1:0]             in_openum,
    input  logic [REG_W-1:0]            in_rd,
    input  logic [REG_W-1:0]            in_rs1,
    input  logic [REG_W-1:0]            in_rs2,
    input  logic [DATA_W-1:0]           in_imm,
    output logic [REG_W-1:0]            rs1_to_reg,
    output logic [REG_W-1:0]            rs2_to_reg,
    input  logic [DATA_W-1:0]           V1_from_reg,
    input  logic [DATA_W-1:0]           V2_from_reg,
    input  logic [ROB_ID_W-1:0]         Q1_from_reg,
    input  logic [ROB_ID_W-1:0]         Q2_from_reg,
    output logic [ROB_ID_W-1:0]         Q1_to_rob,
    output logic [ROB_ID_W-1:0]         Q2_to_rob,
    input  logic                        Q1_ready_from_rob,
    input  logic                        Q2_ready_from_rob,
    input  logic [DATA_W-1:0]           ready_data1_from_rob,
    input  logic [DATA_W-1:0]           ready_data2_from_rob,
    input  logic                        rob_full,
    input  logic                        rs_full,
    input  logic                        lsb_full,
    input  logic [ROB_ID_W-1:0]         rob_id_from_rob,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_result,
    output logic                        ena_to_rob,
    output logic                        ena_to_reg,
    output logic                        ena_to_rs,
    output logic                        ena_to_lsb,
    output logic [REG_W-1:0]            rd_to_rob,
    output logic [REG_W-1:0]            rd_to_reg,
    output logic [OP_W-1:0]             openum_out,
    output logic [DATA_W-1:0]           V1_out,
    output logic [DATA_W-1:0]           V2_out,
    output logic [ROB_ID_W-1:0]         Q1_out,
    output logic [ROB_ID_W-1:0]         Q2_out,
    output logic [DATA_W-1:0]           imm_out,
    output logic [ADDR_W-1:0]           pc_out,
    output logic [ROB_ID_W-1:0]         rob_id_out,
    input  logic                        commit_jump_flag_from_rob
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]                 stall_rob_cnt,
    output logic [31:0]                 stall_rs_cnt,
    output logic [31:0]                 stall_lsb_cnt,
    output logic [31:0]                 issue_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage, one array per decoded field
    logic [ADDR_W-1:0] r_pc_mem  [DEPTH];
    logic [OP_W-1:0]   r_op_mem  [DEPTH];
    logic [REG_W-1:0]  r_rd_mem  [DEPTH];
    logic [REG_W-1:0]  r_rs1_mem [DEPTH];
    logic [REG_W-1:0]  r_rs2_mem [DEPTH];
    logic [DATA_W-1:0] r_imm_mem [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              r_ena_rob;
    logic              r_ena_reg;
    logic              r_ena_rs;
    logic              r_ena_lsb;
    logic [REG_W-1:0]  r_rd_out;
    logic [OP_W-1:0]   r_op_out;
    logic [DATA_W-1:0] r_v1_out;
    logic [DATA_W-1:0] r_v2_out;
    logic [ROB_ID_W-1:0] r_q1_out;
    logic [ROB_ID_W-1:0] r_q2_out;
    logic [DATA_W-1:0] r_imm_out;
    logic [ADDR_W-1:0] r_pc_out;
    logic [ROB_ID_W-1:0] r_rob_id_out;

    logic              w_flush;
    logic              w_nonempty;
    logic              w_push;
    logic              w_pop;
    logic              w_head_is_mem;
    logic              w_unit_full;
    logic [ROB_ID_W-1:0] w_q1;
    logic [ROB_ID_W-1:0] w_q2;
    logic [DATA_W-1:0] w_v1;
    logic [DATA_W-1:0] w_v2;

    assign w_flush       = commit_jump_flag_from_rob;
    assign w_nonempty    = (r_count != '0);
    // in_ready looks only at the registered count, so a pop never frees a slot in the same cycle
    assign in_ready      = (r_count < CNT_W'(DEPTH));
    assign w_push        = in_valid & in_ready & rdy & ~w_flush;
    assign w_head_is_mem = is_mem_op(32'(r_op_mem[r_head]));
    assign w_unit_full   = w_head_is_mem ? lsb_full : rs_full;
    assign w_pop         = w_nonempty & rdy & ~w_flush & ~rob_full & ~w_unit_full;

    // Head entry sources go to the register file combinationally; its tags are looked up in the ROB
    assign rs1_to_reg = r_rs1_mem[r_head];
    assign rs2_to_reg = r_rs2_mem[r_head];
    assign Q1_to_rob  = Q1_from_reg;
    assign Q2_to_rob  = Q2_from_reg;

    operand_resolver #(
        .DATA_W   (DATA_W),
        .ROB_ID_W (ROB_ID_W),
        .NUM_CDB  (NUM_CDB)
    ) u_resolve_rs1 (
        .i_q_from_reg (Q1_from_reg),
        .i_v_from_reg (V1_from_reg),
        .i_rob_ready  (Q1_ready_from_rob),
        .i_rob_data   (ready_data1_from_rob),
        .i_cdb_valid  (cdb_valid),
        .i_cdb_rob_id (cdb_rob_id),
        .i_cdb_result (cdb_result),
        .o_q          (w_q1),
        .o_v          (w_v1)
    );

    operand_resolver #(
        .DATA_W   (DATA_W),
        .ROB_ID_W (ROB_ID_W),
        .NUM_CDB  (NUM_CDB)
    ) u_resolve_rs2 (
        .i_q_from_reg (Q2_from_reg),
        .i_v_from_reg (V2_from_reg),
        .i_rob_ready  (Q2_ready_from_rob),
        .i_rob_data   (ready_data2_from_rob),
        .i_cdb_valid  (cdb_valid),
        .i_cdb_rob_id (cdb_rob_id),
        .i_cdb_result (cdb_result),
        .o_q          (w_q2),
        .o_v          (w_v2)
    );

    // Entry storage is written only on accepted pushes; slots outside head..tail are don't-care
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]  <= in_pc;
            r_op_mem[r_tail]  <= in_openum;
            r_rd_mem[r_tail]  <= in_rd;
            r_rs1_mem[r_tail] <= in_rs1;
            r_rs2_mem[r_tail] <= in_rs2;
            r_imm_mem[r_tail] <= in_imm;
        end
    end

    // Pointer and occupancy bookkeeping; a flush empties the queue and drops same-cycle push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Issue pulses last exactly one cycle; payload latches on issue and otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ena_rob    <= FALSE;
            r_ena_reg    <= FALSE;
            r_ena_rs     <= FALSE;
            r_ena_lsb    <= FALSE;
            r_rd_out     <= '0;
            r_op_out     <= '0;
            r_v1_out     <= '0;
            r_v2_out     <= '0;
            r_q1_out     <= '0;
            r_q2_out     <= '0;
            r_imm_out    <= '0;
            r_pc_out     <= '0;
            r_rob_id_out <= '0;
        end else if (rdy) begin
            r_ena_rob <= w_pop;
            r_ena_reg <= w_pop;
            r_ena_rs  <= w_pop & ~w_head_is_mem;
            r_ena_lsb <= w_pop & w_head_is_mem;
            if (w_pop) begin
                r_rd_out     <= r_rd_mem[r_head];
                r_op_out     <= r_op_mem[r_head];
                r_v1_out     <= w_v1;
                r_v2_out     <= w_v2;
                r_q1_out     <= w_q1;
                r_q2_out     <= w_q2;
                r_imm_out    <= r_imm_mem[r_head];
                r_pc_out     <= r_pc_mem[r_head];
                r_rob_id_out <= rob_id_from_rob;
            end
        end
    end

    assign ena_to_rob = r_ena_rob;
    assign ena_to_reg = r_ena_reg;
    assign ena_to_rs  = r_ena_rs;
    assign ena_to_lsb = r_ena_lsb;
    assign rd_to_rob  = r_rd_out;
    assign rd_to_reg  = r_rd_out;
    assign openum_out = r_op_out;
    assign V1_out     = r_v1_out;
    assign V2_out     = r_v2_out;
    assign Q1_out     = r_q1_out;
    assign Q2_out     = r_q2_out;
    assign imm_out    = r_imm_out;
    assign pc_out     = r_pc_out;
    assign rob_id_out = r_rob_id_out;

`ifdef DISPATCH_STATS_EN
    logic [31:0] r_stall_rob_cnt;
    logic [31:0] r_stall_rs_cnt;
    logic [31:0] r_stall_lsb_cnt;
    logic [31:0] r_issue_cnt;
    logic        w_stall_window;

    assign w_stall_window = w_nonempty & rdy & ~w_flush;

    // Attribute each blocked cycle to one unit, ROB first; counters wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_rob_cnt <= '0;
            r_stall_rs_cnt  <= '0;
            r_stall_lsb_cnt <= '0;
            r_issue_cnt     <= '0;
        end else begin
            if (w_stall_window) begin
                if (rob_full) begin
                    r_stall_rob_cnt <= r_stall_rob_cnt + 32'd1;
                end else if (w_head_is_mem && lsb_full) begin
                    r_stall_lsb_cnt <= r_stall_lsb_cnt + 32'd1;
                end else if (!w_head_is_mem && rs_full) begin
                    r_stall_rs_cnt <= r_stall_rs_cnt + 32'd1;
                end
            end
            if (w_pop) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
        end
    end

    assign stall_rob_cnt = r_stall_rob_cnt;
    assign stall_rs_cnt  = r_stall_rs_cnt;
    assign stall_lsb_cnt = r_stall_lsb_cnt;
    assign issue_cnt     = r_issue_cnt;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - randomized scoreboard bench for dispatch_queue
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int ROB_ID_W = 4;
    localparam int REG_W    = 5;
    localparam int OP_W     = 6;
    localparam int DEPTH    = 4;
    localparam int NUM_CDB  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [ADDR_W-1:0] in_pc = '0;
    logic [OP_W-1:0] in_openum = '0;
    logic [REG_W-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [DATA_W-1:0] in_imm = '0;
    logic [REG_W-1:0] rs1_to_reg, rs2_to_reg;
    logic [DATA_W-1:0] V1_from_reg = '0, V2_from_reg = '0;
    logic [ROB_ID_W-1:0] Q1_from_reg = '0, Q2_from_reg = '0;
    logic [ROB_ID_W-1:0] Q1_to_rob, Q2_to_rob;
    logic Q1_ready_from_rob = 1'b0, Q2_ready_from_rob = 1'b0;
    logic [DATA_W-1:0] ready_data1_from_rob = '0, ready_data2_from_rob = '0;
    logic rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
    logic [ROB_ID_W-1:0] rob_id_from_rob = '0;
    logic [NUM_CDB-1:0] cdb_valid = '0;
    logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id = '0;
    logic [NUM_CDB*DATA_W-1:0] cdb_result = '0;
    logic ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb;
    logic [REG_W-1:0] rd_to_rob, rd_to_reg;
    logic [OP_W-1:0] openum_out;
    logic [DATA_W-1:0] V1_out, V2_out, imm_out;
    logic [ROB_ID_W-1:0] Q1_out, Q2_out, rob_id_out;
    logic [ADDR_W-1:0] pc_out;
    logic commit_jump_flag_from_rob = 1'b0;

    dispatch_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROB_ID_W(ROB_ID_W), .REG_W(REG_W),
        .OP_W(OP_W), .DEPTH(DEPTH), .NUM_CDB(NUM_CDB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_openum(in_openum), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
        .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
        .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
        .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
        .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
        .ready_data1_from_rob(ready_data1_from_rob), .ready_data2_from_rob(ready_data2_from_rob),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rob_id_from_rob(rob_id_from_rob),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
        .ena_to_rob(ena_to_rob), .ena_to_reg(ena_to_reg), .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb),
        .rd_to_rob(rd_to_rob), .rd_to_reg(rd_to_reg),
        .openum_out(openum_out), .V1_out(V1_out), .V2_out(V2_out), .Q1_out(Q1_out), .Q2_out(Q2_out),
        .imm_out(imm_out), .pc_out(pc_out), .rob_id_out(rob_id_out),
        .commit_jump_flag_from_rob(commit_jump_flag_from_rob)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [DATA_W-1:0] imm;
    } ent_t;

    typedef struct {
        logic [3:0]          ena;
        logic [REG_W-1:0]    rd;
        logic [OP_W-1:0]     op;
        logic [DATA_W-1:0]   v1;
        logic [DATA_W-1:0]   v2;
        logic [ROB_ID_W-1:0] q1;
        logic [ROB_ID_W-1:0] q2;
        logic [DATA_W-1:0]   imm;
        logic [ADDR_W-1:0]   pc;
        logic [ROB_ID_W-1:0] rob_id;
    } exp_t;

    ent_t mq[$];
    exp_t exp_q[$];
    exp_t last_e;
    exp_t mon_e;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit tb_is_mem(input logic [OP_W-1:0] op);
        return (int'(op) >= int'(OPENUM_LB)) && (int'(op) <= int'(OPENUM_SW));
    endfunction

    // Pending tag: first matching CDB channel from 0 up, else ROB ready data, else register value
    task automatic resolve(input logic [ROB_ID_W-1:0] q, input logic [DATA_W-1:0] v,
                           input logic rr, input logic [DATA_W-1:0] rdat,
                           output logic [ROB_ID_W-1:0] qo, output logic [DATA_W-1:0] vo);
        bit hit;
        hit = 0;
        qo = q;
        vo = v;
        if (q != 0) begin
            for (int i = 0; i < NUM_CDB; i++) begin
                if (!hit && cdb_valid[i] && cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] == q) begin
                    hit = 1;
                    qo = 0;
                    vo = cdb_result[i*DATA_W +: DATA_W];
                end
            end
            if (!hit && rr) begin
                qo = 0;
                vo = rdat;
            end
        end
    endtask

    // Scoreboard monitor: one expectation per clock edge, compared just after the edge
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ena{rob,reg,rs,lsb}", 64'({ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb}), 64'(mon_e.ena));
            chk("rd_to_rob", 64'(rd_to_rob), 64'(mon_e.rd));
            chk("rd_to_reg", 64'(rd_to_reg), 64'(mon_e.rd));
            chk("openum_out", 64'(openum_out), 64'(mon_e.op));
            chk("V1_out", 64'(V1_out), 64'(mon_e.v1));
            chk("V2_out", 64'(V2_out), 64'(mon_e.v2));
            chk("Q1_out", 64'(Q1_out), 64'(mon_e.q1));
            chk("Q2_out", 64'(Q2_out), 64'(mon_e.q2));
            chk("imm_out", 64'(imm_out), 64'(mon_e.imm));
            chk("pc_out", 64'(pc_out), 64'(mon_e.pc));
            chk("rob_id_out", 64'(rob_id_out), 64'(mon_e.rob_id));
        end
    end

    // One cycle of random stimulus (percent knobs) plus the reference model step for the coming edge
    task automatic step(input int pv, input int prob, input int punit, input int pflush, input int pnrdy);
        exp_t e;
        ent_t h, n;
        int sz;
        bit issue, m;
        @(negedge clk);
        in_valid  = ($urandom_range(99) < pv);
        in_pc     = $urandom;
        in_openum = OP_W'($urandom_range(0, 37));
        in_rd     = REG_W'($urandom);
        in_rs1    = REG_W'($urandom);
        in_rs2    = REG_W'($urandom);
        in_imm    = $urandom;
        rdy       = !($urandom_range(99) < pnrdy);
        rob_full  = ($urandom_range(99) < prob);
        rs_full   = ($urandom_range(99) < punit);
        lsb_full  = ($urandom_range(99) < punit);
        commit_jump_flag_from_rob = ($urandom_range(99) < pflush);
        V1_from_reg = $urandom;
        V2_from_reg = $urandom;
        Q1_from_reg = ROB_ID_W'($urandom_range(0, 3));
        Q2_from_reg = ROB_ID_W'($urandom_range(0, 3));
        Q1_ready_from_rob = 1'($urandom);
        Q2_ready_from_rob = 1'($urandom);
        ready_data1_from_rob = $urandom;
        ready_data2_from_rob = $urandom;
        cdb_valid = NUM_CDB'($urandom);
        for (int i = 0; i < NUM_CDB; i++) begin
            cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] = ROB_ID_W'($urandom_range(0, 3));
            cdb_result[i*DATA_W +: DATA_W] = $urandom;
        end
        rob_id_from_rob = ROB_ID_W'($urandom);
        #1;
        sz = mq.size();
        chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
        chk("Q1_to_rob", 64'(Q1_to_rob), 64'(Q1_from_reg));
        if (sz > 0) begin
            chk("rs1_to_reg", 64'(rs1_to_reg), 64'(mq[0].rs1));
            chk("rs2_to_reg", 64'(rs2_to_reg), 64'(mq[0].rs2));
        end
        e = last_e;
        if (rdy) begin
            e.ena = 4'b0000;
            if (commit_jump_flag_from_rob) begin
                mq.delete();
            end else begin
                m = (sz > 0) ? tb_is_mem(mq[0].op) : 1'b0;
                issue = (sz > 0) && !rob_full && (m ? !lsb_full : !rs_full);
                if (issue) begin
                    h = mq.pop_front();
                    e.ena = {1'b1, 1'b1, !m, m};
                    e.rd = h.rd;
                    e.op = h.op;
                    e.imm = h.imm;
                    e.pc = h.pc;
                    e.rob_id = rob_id_from_rob;
                    resolve(Q1_from_reg, V1_from_reg, Q1_ready_from_rob, ready_data1_from_rob, e.q1, e.v1);
                    resolve(Q2_from_reg, V2_from_reg, Q2_ready_from_rob, ready_data2_from_rob, e.q2, e.v2);
                end
                if (in_valid && sz < DEPTH) begin
                    n.pc = in_pc;
                    n.op = in_openum;
                    n.rd = in_rd;
                    n.rs1 = in_rs1;
                    n.rs2 = in_rs2;
                    n.imm = in_imm;
                    mq.push_back(n);
                end
            end
        end
        exp_q.push_back(e);
        last_e = e;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " ena"}, 64'({ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb}), 64'd0);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " V1_out"}, 64'(V1_out), 64'd0);
        chk({tag, " pc_out"}, 64'(pc_out), 64'd0);
        chk({tag, " rob_id_out"}, 64'(rob_id_out), 64'd0);
        chk({tag, " openum_out"}, 64'(openum_out), 64'd0);
    endtask

    initial begin
        last_e = '{default: 0};
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Mixed traffic with light backpressure, occasional flush and rdy drop
        repeat (300) step(60, 15, 20, 3, 10);

        // RS and LSB blocked: queue fills and in_ready falls, then drains in order back-to-back
        repeat (7) step(100, 0, 100, 0, 0);
        repeat (8) step(0, 0, 0, 0, 0);

        // Three queued entries, then flush while a push is offered
        repeat (3) step(100, 0, 100, 0, 0);
        step(100, 0, 100, 100, 0);
        repeat (4) step(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a burst
        repeat (5) step(100, 0, 30, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        in_valid = 1'b0;
        commit_jump_flag_from_rob = 1'b0;
        mq.delete();
        last_e = '{default: 0};
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(0, 0, 0, 0, 0);

        // Heavier traffic
        repeat (300) step(70, 10, 30, 5, 15);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
